// File: rtl/pc_unit_if.sv
// Signal bundle between the fetch stage (master) and pc_unit (slave): the flow-control
// and target inputs, plus the current, incremented, next and saved exception PCs.
interface pc_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             stall;
  logic [2:0]       brop;
  logic             zero;
  logic             neg;
  logic [WIDTH-1:0] b;
  logic [25:0]      j;
  logic             jump;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             exc;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] npc;
  logic [WIDTH-1:0] epc;
  logic             redirect;
  logic             misalign;

  modport master (
    output stall, brop, zero, neg, b, j, jump, jr, jr_target, exc, eret,
    input  pc, pc4, npc, epc, redirect, misalign
  );

  modport slave (
    input  stall, brop, zero, neg, b, j, jump, jr, jr_target, exc, eret,
    output pc, pc4, npc, epc, redirect, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/jump/register-jump selection and optional exception entry/return.
// Define PC_UNIT_EXC_EN to compile in exc/eret handling, the epc register and the EXC_PEND state.
module pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180)
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    EXC_PEND = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_val;
  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] bpc;
  logic [WIDTH-1:0] jpc;
  logic [WIDTH-1:0] npc_d;
  logic             br_taken;
  logic             exc_req;
  logic             eret_req;
  logic             exc_take;

`ifdef PC_UNIT_EXC_EN
  logic [WIDTH-1:0] epc_q;

  assign exc_req  = bus.exc;
  assign eret_req = bus.eret;
  assign epc_val  = epc_q;
`else
  logic unused_exc_inputs;

  assign exc_req           = 1'b0;
  assign eret_req          = 1'b0;
  assign epc_val           = '0;
  assign unused_exc_inputs = bus.exc ^ bus.eret;
`endif

  assign pc4 = pc_q + WIDTH'(4);
  assign bpc = pc4 + (bus.b << 2);
  assign jpc = {pc4[WIDTH-1:28], bus.j, 2'b00};

  // A pending exception fires on the first unstalled cycle whether or not exc is still high.
  assign exc_take = !bus.stall && ((state_q == RUN && exc_req) || state_q == EXC_PEND);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves br_taken unassigned (no latch).
    br_taken = 1'b0;
    case (bus.brop)
      3'b001:  br_taken = bus.zero;
      3'b010:  br_taken = !bus.zero;
      3'b011:  br_taken = bus.neg | bus.zero;
      3'b100:  br_taken = !bus.neg && !bus.zero;
      3'b101:  br_taken = bus.neg;
      3'b110:  br_taken = !bus.neg;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    npc_d = pc4;
    if (exc_take)      npc_d = EXC_VEC;
    else if (eret_req) npc_d = epc_val;
    else if (bus.jr)   npc_d = bus.jr_target;
    else if (bus.jump) npc_d = jpc;
    else if (br_taken) npc_d = bpc;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
`ifdef PC_UNIT_EXC_EN
      epc_q   <= '0;
`endif
    end else begin
      if (!bus.stall) pc_q <= npc_d;
`ifdef PC_UNIT_EXC_EN
      if (exc_take) epc_q <= pc_q;
`endif
      case (state_q)
        RUN:      if (exc_req && bus.stall) state_q <= EXC_PEND;
        EXC_PEND: if (!bus.stall)           state_q <= RUN;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc4      = pc4;
  assign bus.npc      = npc_d;
  assign bus.epc      = epc_val;
  assign bus.redirect = (npc_d != pc4);
  assign bus.misalign = |npc_d[1:0];

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, 32, PC width in bits; legal values 32 or 64.
REQ-002 Parameter RESET_PC, 32'h0000_3000 zero-extended to WIDTH, PC value after reset.
REQ-003 Parameter EXC_VEC, 32'h0000_4180 zero-extended to WIDTH, exception entry address.
REQ-004 Clocking SHALL be one clock with a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 stall  in  1  hold PC; no update this cycle.
REQ-008 brop  in  3  branch condition: 000 none, 001 eq, 010 ne, 011 lez, 100 gtz, 101 ltz, 110 gez, 111 none.
REQ-009 zero, neg  in  1 each  comparison flags from the ALU for the current instruction.
REQ-010 b  in  WIDTH  sign-extended branch word offset.
REQ-011 j  in  26  jump instruction index.
REQ-012 jump  in  1  active-high absolute jump.
REQ-013 jr, jr_target  in  1, WIDTH  register jump and its target.
REQ-014 exc, eret  in  1 each  exception request; exception return.
REQ-015 pc, pc4, npc  out  WIDTH each  current PC, PC+4, selected next PC.
REQ-016 epc  out  WIDTH  saved exception PC.
REQ-017 redirect  out  1  npc differs from pc4 this cycle.
REQ-018 misalign  out  1  npc[1:0] nonzero.

Function
REQ-019 pc4 SHALL be pc+4 modulo 2^WIDTH; bpc SHALL be pc4+(b<<2) truncated to WIDTH; jpc SHALL be {pc4[WIDTH-1:28], j, 2'b00}.
REQ-020 Branch taken SHALL be: eq=zero, ne=!zero, lez=neg|zero, gtz=!neg&!zero, ltz=neg, gez=!neg; none=0.
REQ-021 npc SHALL be selected with priority: exception take > eret > jr > jump > branch taken > pc4.
REQ-022 npc, pc4, redirect and misalign SHALL be combinational from pc and inputs; pc SHALL load npc at the clock edge when stall=0 and rst=0.
REQ-023 With stall=1, pc, epc and all registered state SHALL hold except the pending-exception latch.
REQ-024 The state machine SHALL have states RUN and EXC_PEND.
REQ-025 RUN: exc=1 with stall=0 takes the exception immediately; exc=1 with stall=1 moves to EXC_PEND.
REQ-026 EXC_PEND: on the first cycle with stall=0, the exception SHALL be taken even if exc has deasserted, and the state returns to RUN.
REQ-027 Exception take SHALL set npc=EXC_VEC and latch epc=pc in the same edge that loads pc.
REQ-028 eret SHALL set npc=epc; eret coincident with exc take SHALL be ignored.
REQ-029 A misaligned target SHALL still be loaded; misalign is advisory only.
REQ-030 Wrap-around: pc=2^WIDTH-4 with no redirect SHALL load 0.

Reset
REQ-031 rst SHALL dominate stall and all requests: pc=RESET_PC, epc=0, state=RUN.
REQ-032 rst asserted in EXC_PEND SHALL discard the pending exception.
REQ-033 Outputs after reset: pc=RESET_PC, pc4=RESET_PC+4, redirect=0 with idle inputs, misalign=0.

Configuration
REQ-034 Macro PC_UNIT_EXC_EN SHALL compile in exception support (exc, eret, epc register, EXC_PEND state).
REQ-035 Without PC_UNIT_EXC_EN, exc and eret SHALL be ignored, epc SHALL be tied to 0, and the state machine SHALL remain in RUN.

Verification
REQ-036 Reset then 3 idle cycles -> pc = 3000, 3004, 3008, 300C.
REQ-037 pc=3000, brop=001, zero=1, b=FFFF_FFFE -> npc=2FFC, redirect=1; same with zero=0 -> npc=3004.
REQ-038 pc=3000, jump=1, j=0x0000040, jr=1, jr_target=5000 -> npc=5000 (jr wins); jr=0 -> npc=0000_0100.
REQ-039 PC_UNIT_EXC_EN defined, pc=3010: exc pulse with stall=1 for 2 cycles, stall released -> pc=4180, epc=3010; eret later -> pc=3010.
REQ-040 pc=FFFF_FFFC idle -> pc=0; jr_target=3002 -> misalign=1 and pc=3002 loaded.
REQ-041 rst asserted while in EXC_PEND -> pc=3000, epc=0, no exception taken after release.
